// File: rtl/uart_tx_serializer_if.sv
// uart_tx_serializer_if
//   Show-ahead FIFO read port between the TX FIFO and the TX serializer.
//
//   Handshake: fifo_data is valid whenever fifo_empty=0 (show-ahead head).
//   The consumer takes the head byte by asserting pop for exactly one clock.
//   The FIFO advances its head on that cycle. pop is never raised while
//   fifo_empty=1. fifo_empty may lag pop by one clock.
//
//   Signals:
//     fifo_empty  FIFO -> serializer  1 = no byte available
//     fifo_data   FIFO -> serializer  head byte
//     pop         serializer -> FIFO  one-cycle consume strobe
//
//   Modports: master = FIFO side, slave = serializer side.
interface uart_tx_serializer_if;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       pop;

    modport master (output fifo_empty, output fifo_data, input pop);
    modport slave  (input fifo_empty, input fifo_data, output pop);
endinterface

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   UART transmit serializer. Pops bytes from a show-ahead TX FIFO and
//   shifts them onto txd as asynchronous frames:
//     - start bit;
//     - 5..8 data bits, LSB first;
//     - optional parity bit;
//     - 1 or 2 stop bits.
//   Bit timing comes from baud_en, an oversample tick. Each bit lasts
//   OVERSAMPLE ticks.
//
//   Optional feature: define UART_TX_BREAK_EN to make brk force txd low
//   after the txd register. The FSM keeps running underneath.
//
//   Parameters:
//     OVERSAMPLE  baud_en ticks per bit; a power of two from 4 to 16.
//
//   Ports:
//     clk, rstn     clock; asynchronous active-low reset
//     baud_en       one-clock oversample tick
//     fifo          FIFO read port (slave modport: fifo_empty, fifo_data, pop)
//     word_len      00=5, 01=6, 10=7, 11=8 data bits
//     stop_bits     0 = one stop bit, 1 = two stop bits
//     parity_en     1 = append a parity bit
//     even_parity   1 = even parity, 0 = odd parity
//     stick_parity  1 = parity bit forced to ~even_parity
//     brk           break request (only with UART_TX_BREAK_EN)
//     txd           serial output; idles at 1
//     tx_busy       high in every state except IDLE
//     tx_idle       IDLE and FIFO empty (transmitter empty)
//     state_dbg     current FSM state:
//                   0=IDLE, 1=START, 2=DATA, 3=PARITY, 4=STOP
module uart_tx_serializer #(
    parameter int OVERSAMPLE = 16
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       baud_en,
    uart_tx_serializer_if.slave        fifo,
    input  logic [1:0]                 word_len,
    input  logic                       stop_bits,
    input  logic                       parity_en,
    input  logic                       even_parity,
    input  logic                       stick_parity,
    input  logic                       brk,
    output logic                       txd,
    output logic                       tx_busy,
    output logic                       tx_idle,
    output logic [2:0]                 state_dbg
);
    localparam int TW = $clog2(OVERSAMPLE);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    bit_q, bit_d;     // data-bit index in DATA, stop-bit index in STOP
    logic [7:0]    shift_q, shift_d;
    logic          acc_q, acc_d;     // running XOR of the data bits sent so far
    logic [1:0]    wlen_q, wlen_d;
    logic          stop2_q, stop2_d;
    logic          par_en_q, par_en_d;
    logic          even_q, even_d;
    logic          stick_q, stick_d;
    logic          txd_q, txd_d;
    logic          pop_q, pop_d;

    logic bit_end;
    logic last_data;
    logic par_bit;
    logic load;

    assign bit_end   = baud_en && (tick_q == TW'(OVERSAMPLE - 1));
    assign last_data = (bit_q == ({1'b0, wlen_q} + 3'd4));
    assign par_bit   = stick_q ? ~even_q : (even_q ? acc_q : ~acc_q);

    // A byte is taken either from IDLE on a tick, or at the final stop-bit
    // end so back-to-back frames have no idle gap.
    assign load = !fifo.fifo_empty &&
                  (((state_q == IDLE) && baud_en) ||
                   ((state_q == STOP) && bit_end && !(stop2_q && (bit_q == 3'd0))));

    always_comb begin
        state_d  = state_q;
        tick_d   = baud_en ? tick_q + 1'b1 : tick_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        acc_d    = acc_q;
        wlen_d   = wlen_q;
        stop2_d  = stop2_q;
        par_en_d = par_en_q;
        even_d   = even_q;
        stick_d  = stick_q;
        txd_d    = txd_q;
        pop_d    = 1'b0;

        case (state_q)
            IDLE: begin
                tick_d = '0;
                txd_d  = 1'b1;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    txd_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                    acc_d   = acc_q ^ shift_q[0];
                    bit_d   = 3'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (last_data) begin
                        bit_d = 3'd0;
                        if (par_en_q) begin
                            state_d = PARITY;
                            txd_d   = par_bit;
                        end else begin
                            state_d = STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        txd_d   = shift_q[0];
                        shift_d = shift_q >> 1;
                        acc_d   = acc_q ^ shift_q[0];
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    txd_d   = 1'b1;
                    bit_d   = 3'd0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop2_q && (bit_q == 3'd0)) begin
                        bit_d = 3'd1;
                    end else begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase

        // Frame load overrides whatever the state decided above.
        if (load) begin
            state_d  = START;
            tick_d   = '0;
            bit_d    = 3'd0;
            shift_d  = fifo.fifo_data;
            acc_d    = 1'b0;
            wlen_d   = word_len;
            stop2_d  = stop_bits;
            par_en_d = parity_en;
            even_d   = even_parity;
            stick_d  = stick_parity;
            txd_d    = 1'b0;
            pop_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            bit_q    <= 3'd0;
            shift_q  <= 8'h00;
            acc_q    <= 1'b0;
            wlen_q   <= 2'b00;
            stop2_q  <= 1'b0;
            par_en_q <= 1'b0;
            even_q   <= 1'b0;
            stick_q  <= 1'b0;
            txd_q    <= 1'b1;
            pop_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            acc_q    <= acc_d;
            wlen_q   <= wlen_d;
            stop2_q  <= stop2_d;
            par_en_q <= par_en_d;
            even_q   <= even_d;
            stick_q  <= stick_d;
            txd_q    <= txd_d;
            pop_q    <= pop_d;
        end
    end

    assign fifo.pop  = pop_q;
    assign tx_busy   = (state_q != IDLE);
    assign tx_idle   = (state_q == IDLE) && fifo.fifo_empty;
    assign state_dbg = state_q;

`ifdef UART_TX_BREAK_EN
    // Break gates the registered line so frame timing is untouched.
    assign txd = txd_q & ~brk;
`else
    logic unused_brk;
    assign unused_brk = brk;
    assign txd        = txd_q;
`endif

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Transmit serializer for the APB UART. It sits directly downstream of the 16-deep TX FIFO. It pops bytes from the FIFO's show-ahead output and shifts them onto the serial line as asynchronous frames: start bit, 5–8 data bits LSB first, optional parity, and 1 or 2 stop bits. Bit timing comes from a 16x oversample enable supplied by the baud generator.

## Interface
Parameters:
- OVERSAMPLE, 16: baud_en pulses per serial bit; legal values are powers of two from 4 to 16.

Ports:
- Reset is asynchronous, active-low. Single clock domain.
- clk  input  1  system clock; everything is sampled on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- baud_en  input  1  one-clk-wide oversample tick.
- fifo_empty  input  1  TX FIFO empty flag.
- fifo_data  input  8  TX FIFO head byte; valid whenever fifo_empty=0.
- word_len  input  2  data bits: 00=5, 01=6, 10=7, 11=8.
- stop_bits  input  1  0 = one stop bit, 1 = two stop bits.
- parity_en  input  1  1 = append a parity bit.
- even_parity  input  1  1 = even parity, 0 = odd parity.
- stick_parity  input  1  1 = parity bit forced to ~even_parity.
- brk  input  1  break request; used only with UART_TX_BREAK_EN.
- pop  output  1  registered one-cycle FIFO pop strobe.
- txd  output  1  serial output; idle level is 1.
- tx_busy  output  1  high while a frame is in progress.
- tx_idle  output  1  high when state=IDLE and fifo_empty=1 (16550 TEMT).

## Operation
- Reset values: txd=1, pop=0, tx_busy=0, tx_idle=1, state=IDLE, tick counter=0, bit counter=0.
- States: IDLE, START, DATA, PARITY, STOP.
- **IDLE.** On a clock where baud_en=1 and fifo_empty=0, the block does all of the following on the same edge:
  - latches fifo_data into the shift register;
  - latches word_len, stop_bits, parity_en, even_parity and stick_parity;
  - sets pop<=1 and txd<=0;
  - goes to START.
- Tick counter (log2(OVERSAMPLE) bits):
  - cleared on entry to each state;
  - incremented on each baud_en.
  - A bit ends on the baud_en where the counter equals OVERSAMPLE-1.
- **START → DATA.** txd drives shift[0] and the register shifts right at each bit end. After word_len+5 data bits:
  - go to PARITY if parity_en=1;
  - otherwise go to STOP.
- **PARITY.** The parity bit covers only the transmitted data bits.
  - even: XOR of the data bits;
  - odd: XNOR of the data bits;
  - stick: ~even_parity.
- **STOP.** txd=1 for 1 or 2 bit periods. At the final bit end:
  - if fifo_empty=0: load the next byte, pop, and go to START on the same edge, so there is no idle gap;
  - otherwise: go to IDLE.
- Configuration inputs that change mid-frame take effect at the next frame only.
- pop is never asserted while fifo_empty=1. pop is high for exactly one cycle per byte.
- tx_busy is high in every state except IDLE.

## Timing
- Start-bit latency: txd falls on the clk edge that samples the qualifying baud_en in IDLE. pop is high during the following cycle.
- Every bit lasts exactly OVERSAMPLE baud_en pulses.
- Frame length is (1 + N + P + S) × OVERSAMPLE baud_en pulses.
- fifo_empty may lag pop by one cycle. The next load is at least one bit period away, so the stale flag is harmless.
- Asynchronous reset mid-frame: txd=1 and pop=0 immediately. The partial frame is abandoned and the latched byte is lost.
- If baud_en=1 and the FIFO becomes non-empty in the same cycle, the byte is loaded (fifo_data is already valid).

## Configuration
- UART_TX_BREAK_EN defined: while brk=1, txd is forced to 0 (combinational AND after the txd register).
  - The state machine keeps running underneath, so frames in progress are corrupted but timing is preserved.
  - tx_busy and pop are unaffected.
- Not defined: brk is ignored and txd comes straight from the register. The port remains so the top-level wiring is identical.

## Test plan
- 8N1, byte 0x55, baud_en every cycle:
  - txd = 0,1,0,1,0,1,0,1,0,1, each bit held 16 cycles;
  - one pop pulse;
  - tx_idle returns to 1 after 160 cycles.
- 7E1, byte 0x41: data 1,0,0,0,0,0,1, then parity 0, then stop 1; frame is 160 ticks.
- 5O2, byte 0x1F: data 1,1,1,1,1, then parity 0, then two stop bits; frame is 144 ticks.
- Two bytes (0xA5, 0x3C) queued, 8N1:
  - the second start bit follows the stop bit with zero gap;
  - two pop pulses exactly 160 ticks apart;
  - tx_busy stays high for 320 ticks.
- rstn asserted at tick 50 of a frame:
  - txd=1 and pop=0 immediately;
  - after rstn releases, the next FIFO byte transmits cleanly.
- With UART_TX_BREAK_EN, brk=1 for 40 ticks during 0xFF 8N1:
  - txd=0 throughout those 40 ticks;
  - the frame ends on schedule at tick 160.
